// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus plus the instruction register handoff
// to the decoder, bundled for the fetch sequencer.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic [31:0] ir_instr;
  logic [31:0] ir_pc;
  logic        ir_ready;

  modport master (
    output imem_req, imem_addr, ir_valid, ir_instr, ir_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_instr, ir_pc,
    output imem_gnt, imem_rvalid, imem_rdata, ir_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with redirect handling and a
// sticky misaligned-target error.
//
// state  | meaning
// S_REQ  | request driven at pc, waiting for grant
// S_WAIT | request accepted, waiting for response (dropped if discard set)
// S_HOLD | instruction presented to decoder until consumed or redirected
// S_ERR  | misaligned redirect seen; idle until reset
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               fetch_err,
  output logic [31:0]        instr_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        discard, discard_nxt;
  logic [31:0] ir_instr, ir_pc;
  logic        load_ir;
  logic        count_inc;
  logic        err_set;
  logic        redir_ok, redir_bad;

  assign redir_ok  = redirect & (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect & (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      discard     <= 1'b0;
      ir_instr    <= 32'h0;
      ir_pc       <= 32'h0;
      fetch_err   <= 1'b0;
      instr_count <= 32'h0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
      if (load_ir) begin
        ir_instr <= bus.imem_rdata;
        ir_pc    <= pc;
      end
      if (err_set) fetch_err <= 1'b1;
      if (count_inc) instr_count <= instr_count + 32'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    load_ir     = 1'b0;
    count_inc   = 1'b0;
    err_set     = 1'b0;
    case (state)
      S_REQ: begin
        if (redir_bad) begin
          state_nxt = S_ERR;
          err_set   = 1'b1;
        end else if (bus.imem_gnt) begin
          state_nxt = S_WAIT;
          // A grant coinciding with a redirect fetches the old target: mark it stale.
          if (redir_ok) begin
            pc_nxt      = redirect_pc;
            discard_nxt = 1'b1;
          end
        end else if (redir_ok) begin
          pc_nxt = redirect_pc;
        end
      end
      S_WAIT: begin
        if (redir_bad) begin
          state_nxt = S_ERR;
          err_set   = 1'b1;
        end else if (bus.imem_rvalid) begin
          if (discard || redir_ok) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
            if (redir_ok) pc_nxt = redirect_pc;
          end else begin
            load_ir   = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (redir_ok) begin
          discard_nxt = 1'b1;
          pc_nxt      = redirect_pc;
        end
      end
      S_HOLD: begin
        if (redir_bad) begin
          state_nxt = S_ERR;
          err_set   = 1'b1;
        end else if (redir_ok) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_REQ;
        end else if (bus.ir_ready) begin
          pc_nxt    = pc + 32'd4;
          count_inc = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  assign bus.imem_req  = (state == S_REQ);
  assign bus.imem_addr = pc;
  assign bus.ir_valid  = (state == S_HOLD);
  assign bus.ir_instr  = ir_instr;
  assign bus.ir_pc     = ir_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a stream-level model predicts which
// address/word each consumed instruction must carry, plus directed scenarios.
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_err;
  logic [31:0] instr_count;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0004_2403;
    if (a == 32'h4) return 32'h0006_0613;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  // stimulus knobs
  int gnt_pct = 100, rdy_pct = 100, redir_pct = 0, spur_pct = 0, max_lat = 1;
  logic        force_redir = 1'b0;
  logic [31:0] force_pc = 32'h0;

  // reference state: next address the core must see, consumptions, error flag
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_cnt = 32'h0;
  logic        err_exp = 1'b0;
  // memory model
  logic        outstanding = 1'b0;
  int          dly = 0;
  logic [31:0] gaddr = 32'h0;
  // per-cycle history
  logic        hold_prev = 1'b0, drop_prev = 1'b0;
  logic [31:0] prev_instr = 32'h0, prev_pc = 32'h0;
  int          since = 0;

  task automatic step();
    logic        rd, ry, consumed;
    logic [31:0] rpc;
    @(negedge clk);
    chk("instr_count", instr_count, exp_cnt);
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, err_exp});
    if (outstanding || err_exp) chk("req_idle", {31'd0, bus.imem_req}, 32'd0);
    if (bus.ir_valid) chk("req_in_hold", {31'd0, bus.imem_req}, 32'd0);
    if (err_exp) chk("valid_in_err", {31'd0, bus.ir_valid}, 32'd0);
    if (hold_prev) begin
      chk("hold_valid", {31'd0, bus.ir_valid}, 32'd1);
      chk("hold_instr", bus.ir_instr, prev_instr);
      chk("hold_pc", bus.ir_pc, prev_pc);
    end
    if (drop_prev) chk("redir_drop", {31'd0, bus.ir_valid}, 32'd0);

    bus.imem_rvalid = 1'b0;
    bus.imem_gnt    = 1'b0;
    if (outstanding) begin
      dly--;
      if (dly == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem(gaddr);
        outstanding     = 1'b0;
      end
    end else if ($urandom_range(0, 99) < spur_pct) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = $urandom;
    end
    if (bus.imem_req && !outstanding && $urandom_range(0, 99) < gnt_pct) begin
      bus.imem_gnt = 1'b1;
      outstanding  = 1'b1;
      gaddr        = bus.imem_addr;
      dly          = int'($urandom_range(1, max_lat));
    end

    ry = ($urandom_range(0, 99) < rdy_pct);
    bus.ir_ready = ry;
    rd  = 1'b0;
    rpc = 32'h0;
    if (force_redir) begin
      rd = 1'b1; rpc = force_pc; force_redir = 1'b0;
    end else if ($urandom_range(0, 99) < redir_pct) begin
      rd  = 1'b1;
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 255)) << 2);
    end
    redirect    = rd;
    redirect_pc = rpc;

    consumed   = bus.ir_valid && ry && !rd && !err_exp;
    hold_prev  = bus.ir_valid && !ry && !rd && !err_exp;
    drop_prev  = bus.ir_valid && rd;
    prev_instr = bus.ir_instr;
    prev_pc    = bus.ir_pc;
    if (!err_exp) begin
      if (rd && rpc[1:0] != 2'b00) err_exp = 1'b1;
      else if (rd) exp_pc = rpc;
      else if (consumed) begin
        chk("cons_pc", bus.ir_pc, exp_pc);
        chk("cons_instr", bus.ir_instr, mem(exp_pc));
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 32'd1;
      end
    end
    if (consumed) since = 0;
    else since++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    chk("rst_valid", {31'd0, bus.ir_valid}, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_instr", bus.ir_instr, 32'd0);
    chk("rst_pc", bus.ir_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_pc = RESET_PC; exp_cnt = 32'h0; err_exp = 1'b0;
    outstanding = 1'b0; hold_prev = 1'b0; drop_prev = 1'b0; since = 0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.ir_valid && n < 20) begin step(); n++; end
    if (!bus.ir_valid) chk(tag, {31'd0, bus.ir_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!bus.imem_req && n < 20) begin step(); n++; end
    if (!bus.imem_req) chk(tag, {31'd0, bus.imem_req}, 32'd1);
  endtask

  initial begin
    logic [31:0] c0, i0, p0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.ir_ready = 1'b0;

    // two-instruction zero-wait stream after reset
    do_reset();
    step(); chk("a_req0", {31'd0, bus.imem_req}, 32'd1); chk("a_addr0", bus.imem_addr, RESET_PC);
    step(); chk("a_wait_req", {31'd0, bus.imem_req}, 32'd0);
    step(); chk("a_valid0", {31'd0, bus.ir_valid}, 32'd1);
    chk("a_instr0", bus.ir_instr, 32'h0004_2403); chk("a_pc0", bus.ir_pc, 32'h0);
    step(); chk("a_req1", {31'd0, bus.imem_req}, 32'd1); chk("a_addr1", bus.imem_addr, 32'h4);
    step();
    step(); chk("a_instr1", bus.ir_instr, 32'h0006_0613); chk("a_pc1", bus.ir_pc, 32'h4);
    step(); chk("a_count", instr_count, 32'd2);

    // grant withheld, then decoder stalls in HOLD
    do_reset();
    gnt_pct = 0;
    repeat (5) begin
      step();
      chk("b_req", {31'd0, bus.imem_req}, 32'd1);
      chk("b_addr", bus.imem_addr, 32'h0);
      chk("b_valid", {31'd0, bus.ir_valid}, 32'd0);
    end
    gnt_pct = 100; rdy_pct = 0;
    wait_valid("c_reach_hold");
    c0 = instr_count; i0 = bus.ir_instr; p0 = bus.ir_pc;
    repeat (4) begin
      step();
      chk("c_instr", bus.ir_instr, i0);
      chk("c_pc", bus.ir_pc, p0);
      chk("c_req", {31'd0, bus.imem_req}, 32'd0);
      chk("c_count", instr_count, c0);
    end
    rdy_pct = 100;

    // redirect while the response is pending
    do_reset();
    max_lat = 3;
    step();
    force_redir = 1'b1; force_pc = 32'h100;
    step();
    wait_req("d_reach_req");
    chk("d_addr", bus.imem_addr, 32'h100);
    wait_valid("d_reach_hold");
    chk("d_pc", bus.ir_pc, 32'h100);
    chk("d_instr", bus.ir_instr, mem(32'h100));
    max_lat = 1;

    // redirect beats ir_ready in HOLD
    do_reset();
    rdy_pct = 0;
    wait_valid("e_reach_hold");
    c0 = instr_count;
    rdy_pct = 100; force_redir = 1'b1; force_pc = 32'h40;
    step();
    step();
    chk("e_valid", {31'd0, bus.ir_valid}, 32'd0);
    chk("e_count", instr_count, c0);
    chk("e_addr", bus.imem_addr, 32'h40);

    // misaligned target is sticky until reset
    force_redir = 1'b1; force_pc = 32'h102;
    step();
    repeat (5) begin
      step();
      chk("f_err", {31'd0, fetch_err}, 32'd1);
      chk("f_req", {31'd0, bus.imem_req}, 32'd0);
    end
    do_reset();
    step();
    chk("f_req_after", {31'd0, bus.imem_req}, 32'd1);
    chk("f_addr_after", bus.imem_addr, RESET_PC);

    // random traffic with a reset in the middle
    do_reset();
    gnt_pct = 60; rdy_pct = 70; redir_pct = 3; spur_pct = 5; max_lat = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step();
      if (since > 100) begin
        chk("progress", 32'(since), 32'd0);
        since = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL signal an instruction-memory read request.
REQ-005 imem_addr  output  32  SHALL carry the byte address of the request.
REQ-006 imem_gnt  input  1  SHALL indicate the request is accepted this cycle (imem_req & imem_gnt).
REQ-007 imem_rvalid  input  1  SHALL indicate imem_rdata is valid, exactly one cycle per accepted request.
REQ-008 imem_rdata  input  32  SHALL carry the instruction word.
REQ-009 ir_valid  output  1  SHALL indicate ir_instr/ir_pc hold an instruction for the decoder.
REQ-010 ir_instr  output  32  SHALL carry the latched instruction word to the field decoder.
REQ-011 ir_pc  output  32  SHALL carry the address of ir_instr.
REQ-012 ir_ready  input  1  SHALL indicate the core consumes the instruction (ir_valid & ir_ready).
REQ-013 redirect  input  1  SHALL request a fetch-stream change (branch/jump).
REQ-014 redirect_pc  input  32  SHALL carry the redirect target.
REQ-015 fetch_err  output  1  SHALL flag a sticky misaligned-target error.
REQ-016 instr_count  output  32  SHALL count consumed instructions.

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD, ERR; at most one request outstanding.
REQ-018 REQ: imem_req=1, imem_addr=pc; on imem_gnt go to WAIT; else stay.
REQ-019 WAIT: imem_req=0; on imem_rvalid latch ir_instr=imem_rdata, ir_pc=pc, go to HOLD.
REQ-020 HOLD: ir_valid=1, ir_instr/ir_pc stable; on ir_ready set pc=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), go to REQ.
REQ-021 Zero-wait memory (gnt in cycle N, rvalid N+1) SHALL give ir_valid in cycle N+2; next imem_req one cycle after consumption.
REQ-022 ir_valid SHALL be 0 in every state other than HOLD.
REQ-023 instr_count SHALL increment by 1 on each ir_valid & ir_ready cycle, wrapping at 2^32.
REQ-024 Redirect in REQ without gnt: pc=redirect_pc next cycle, stay in REQ (address may change before grant).
REQ-025 Redirect in REQ with gnt same cycle: request counted as stale; go to WAIT with pc=redirect_pc and discard flag set.
REQ-026 Redirect in WAIT: set discard flag, pc=redirect_pc; stay in WAIT.
REQ-027 Response in WAIT with discard flag set (including redirect in same cycle as rvalid) SHALL be dropped, flag cleared, go to REQ at pc (newest target).
REQ-028 Redirect in HOLD SHALL take priority over ir_ready: ir_valid drops next cycle, no count increment, pc=redirect_pc, go to REQ.
REQ-029 Redirect with redirect_pc[1:0]!=0 SHALL set fetch_err, enter ERR; ERR: imem_req=0, ir_valid=0, any outstanding response ignored, exit only by reset.
REQ-030 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-031 rst low SHALL immediately force: state=REQ, pc=RESET_PC, discard=0, ir_instr=0, ir_pc=0, ir_valid=0, fetch_err=0, instr_count=0.
REQ-032 Reset asserted mid-transaction SHALL abandon it; first cycle after release imem_req=1, imem_addr=RESET_PC.

Verification
REQ-033 Reset release, zero-wait memory returning 32'h00042403 at 0 and 32'h00060613 at 4, ir_ready=1 -> ir_instr 00042403/ir_pc 0 then 00060613/ir_pc 4; instr_count=2.
REQ-034 imem_gnt held low 5 cycles -> imem_req and imem_addr=0 stable 5 cycles, ir_valid stays 0.
REQ-035 ir_ready low 4 cycles in HOLD -> ir_instr/ir_pc stable, no new imem_req, instr_count unchanged.
REQ-036 Redirect to 32'h100 in WAIT -> pending rdata dropped, next imem_addr=32'h100, ir_pc=32'h100.
REQ-037 Redirect to 32'h40 with ir_ready=1 in HOLD -> no count increment, next imem_addr=32'h40.
REQ-038 Redirect to 32'h102 -> fetch_err=1, imem_req=0 until rst low; after release imem_addr=RESET_PC.
